// File: rtl/cmp_sar_search.sv
// Successive-approximation search engine driving the probe operand of an
// external eq/gt/lt magnitude comparator to recover the value on its other side.
module cmp_sar_search #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] probe,
    output logic             probe_valid,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int KW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        VERIFY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic [KW-1:0]    k;
    logic             legal;

    assign legal = (cmp_eq & ~cmp_gt & ~cmp_lt) |
                   (~cmp_eq & cmp_gt & ~cmp_lt) |
                   (~cmp_eq & ~cmp_gt & cmp_lt);

    // probe below target: the trial bit is kept in the accumulator
    assign acc_n = cmp_lt ? probe : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = PROBE;
                end
            end
            PROBE: begin
                if (abort || !legal || cmp_eq) begin
                    state_n = DONE;
                end else if (k == '0) begin
                    state_n = VERIFY;
                end
            end
            VERIFY: state_n = DONE;
            DONE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == PROBE) || (state == VERIFY);
        probe_valid = busy;
        done        = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe  <= '0;
            acc    <= '0;
            k      <= '0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        k      <= KW'(WIDTH - 1);
                        probe  <= ONE << (WIDTH - 1);
                        result <= '0;
                        found  <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                PROBE: begin
                    if (abort) begin
                        err    <= 1'b1;
                        found  <= 1'b0;
                        result <= acc;
                    end else if (!legal) begin
                        err <= 1'b1;
                    end else if (cmp_eq) begin
                        result <= probe;
                        found  <= 1'b1;
                    end else begin
                        acc <= acc_n;
                        if (k == '0) begin
                            probe <= acc_n;
                        end else begin
                            k     <= k - 1'b1;
                            probe <= acc_n | (ONE << (k - 1'b1));
                        end
                    end
                end
                VERIFY: begin
                    result <= acc;
                    if (abort) begin
                        err   <= 1'b1;
                        found <= 1'b0;
                    end else if (!legal) begin
                        err <= 1'b1;
                    end else if (cmp_eq) begin
                        found <= 1'b1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_sar_search.sv
// Directed bench for cmp_sar_search against a behavioural comparator
// with fault and abort injection keyed to the probe number.
module tb_cmp_sar_search;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] probe;
    logic       probe_valid;
    logic       cmp_eq;
    logic       cmp_gt;
    logic       cmp_lt;
    logic       busy;
    logic       done;
    logic       found;
    logic       err;
    logic [7:0] result;

    logic [7:0] target;
    logic       bad;

    int errors = 0;
    int checks = 0;

    logic [7:0] plist [0:15];
    int nprobe;
    int bad_at;
    int abort_at;
    int spam_at;
    logic err_c1;
    logic busy_c1;

    cmp_sar_search #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .probe(probe),
        .probe_valid(probe_valid),
        .cmp_eq(cmp_eq),
        .cmp_gt(cmp_gt),
        .cmp_lt(cmp_lt),
        .busy(busy),
        .done(done),
        .found(found),
        .err(err),
        .result(result)
    );

    assign cmp_eq = !bad && (probe == target);
    assign cmp_gt = !bad && (probe > target);
    assign cmp_lt = !bad && (probe < target);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [7:0] tgt, output int cyc);
        target = tgt;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cyc    = 1;
        nprobe = 0;
        err_c1 = err;
        busy_c1 = busy;
        while (cyc < 40) begin
            if (done) break;
            if (probe_valid) begin
                if (nprobe < 16) plist[nprobe] = probe;
                nprobe++;
            end
            bad   = (nprobe == bad_at);
            abort = (nprobe == abort_at);
            start = (nprobe == spam_at);
            @(negedge clk);
            cyc++;
        end
        bad   = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        check("timeout", 32'(cyc < 40), 32'd1);
    endtask

    task automatic after_done();
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    logic [7:0] exp5a [0:6];
    int cyc;

    initial begin
        exp5a[0] = 8'h80; exp5a[1] = 8'h40; exp5a[2] = 8'h60;
        exp5a[3] = 8'h50; exp5a[4] = 8'h58; exp5a[5] = 8'h5C;
        exp5a[6] = 8'h5A;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        bad = 1'b0; target = 8'h00;
        bad_at = 0; abort_at = 0; spam_at = 0;
        repeat (2) @(negedge clk);
        check("rst_probe", 32'(probe), 32'h0);
        check("rst_flags", 32'({probe_valid, busy, done, found, err}), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x5A: early eq on probe 7
        run(8'h5A, cyc);
        check("5a_cyc", 32'(cyc), 32'd8);
        check("5a_busy_c1", 32'(busy_c1), 32'd1);
        check("5a_nprobe", 32'(nprobe), 32'd7);
        for (int i = 0; i < 7; i++)
            check($sformatf("5a_probe%0d", i), 32'(plist[i]), 32'(exp5a[i]));
        check("5a_result", 32'(result), 32'h5A);
        check("5a_found", 32'(found), 32'd1);
        check("5a_err", 32'(err), 32'd0);
        after_done();

        // 0x00: all gt, resolved in verify
        run(8'h00, cyc);
        check("00_cyc", 32'(cyc), 32'd10);
        check("00_nprobe", 32'(nprobe), 32'd9);
        check("00_p7", 32'(plist[7]), 32'h01);
        check("00_verify", 32'(plist[8]), 32'h00);
        check("00_result", 32'(result), 32'h00);
        check("00_found", 32'(found), 32'd1);
        check("00_err", 32'(err), 32'd0);
        after_done();

        // 0xFF: eq on last probe, no verify
        run(8'hFF, cyc);
        check("ff_cyc", 32'(cyc), 32'd9);
        check("ff_nprobe", 32'(nprobe), 32'd8);
        check("ff_p6", 32'(plist[6]), 32'hFE);
        check("ff_result", 32'(result), 32'hFF);
        check("ff_found", 32'(found), 32'd1);
        after_done();

        // illegal verdict on probe 3
        bad_at = 3;
        run(8'h77, cyc);
        bad_at = 0;
        check("bad_cyc", 32'(cyc), 32'd4);
        check("bad_err", 32'(err), 32'd1);
        check("bad_found", 32'(found), 32'd0);
        after_done();
        run(8'h12, cyc);
        check("clr_err_c1", 32'(err_c1), 32'd0);
        check("clr_result", 32'(result), 32'h12);
        check("clr_err", 32'(err), 32'd0);
        after_done();

        // abort on probe 4, start spam while busy
        abort_at = 4;
        spam_at = 2;
        run(8'h33, cyc);
        abort_at = 0;
        spam_at = 0;
        check("ab_cyc", 32'(cyc), 32'd5);
        check("ab_err", 32'(err), 32'd1);
        check("ab_found", 32'(found), 32'd0);
        check("ab_result", 32'(result), 32'h20);
        after_done();
        repeat (3) @(negedge clk);
        check("ab_no_restart", 32'(busy), 32'd0);

        // async reset mid-search
        target = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_probe", 32'(probe), 32'h0);
        check("mid_rst_flags", 32'({probe_valid, busy, done, found, err}), 32'h0);
        check("mid_rst_result", 32'(result), 32'h0);
        @(negedge clk);
        check("mid_rst_nodone", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run(8'hA5, cyc);
        check("a5_cyc", 32'(cyc), 32'd9);
        check("a5_result", 32'(result), 32'hA5);
        check("a5_found", 32'(found), 32'd1);
        after_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
